// File: rtl/seed_gf256_pow.sv
// Serial x^247 / x^251 exponentiation in GF(2^8) mod 0x163 for the SEED S1/S2 path.
// One shared multiplier, left-to-right square-and-multiply, constant 15-cycle latency.
module seed_gf256_pow (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StSq, StMul} state_e;

  state_e      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  x_q, x_d;
  logic        esel_q, esel_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  dout_q, dout_d;
  logic        done_q, done_d;

  logic [7:0]  mul_b;
  logic [7:0]  mul_p;
  logic [7:0]  exp_bits;
  logic        exp_bit;

  // Polynomial-basis multiply; x^8 folds back as x^6+x^5+x+1 (0x63).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h63 : 8'h00);
    end
    return p;
  endfunction

  assign mul_b    = (state_q == StSq) ? acc_q : x_q;
  assign mul_p    = gf_mul(acc_q, mul_b);
  assign exp_bits = esel_q ? 8'hFB : 8'hF7;
  assign exp_bit  = exp_bits[bit_idx_q];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_d       = x_q;
    esel_d    = esel_q;
    bit_idx_d = bit_idx_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          // Bit 7 is set in both exponents, so the accumulator starts at x.
          acc_d     = din;
          x_d       = din;
          esel_d    = sel;
          bit_idx_d = 3'd6;
          state_d   = StSq;
        end
      end
      StSq: begin
        acc_d   = mul_p;
        state_d = StMul;
      end
      StMul: begin
        acc_d = exp_bit ? mul_p : acc_q;
        if (bit_idx_q == 3'd0) begin
          dout_d  = acc_d;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          bit_idx_d = bit_idx_q - 3'd1;
          state_d   = StSq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= 8'h00;
      x_q       <= 8'h00;
      esel_q    <= 1'b0;
      bit_idx_q <= 3'd0;
      dout_q    <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      esel_q    <= esel_d;
      bit_idx_q <= bit_idx_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
    end
  end

  assign dout = dout_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_seed_gf256_pow.sv
// Directed and exhaustive checks of seed_gf256_pow against a brute-force GF(2^8)/0x163 model.
module tb_seed_gf256_pow;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       done;

  int errors;
  int checks;

  seed_gf256_pow dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sel  (sel),
    .din  (din),
    .dout (dout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schoolbook product followed by reduction from the top bit down.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    logic [14:0] poly;
    prod = 15'd0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) begin
      poly = 15'h163 << (k - 8);
      if (prod[k]) prod = prod ^ poly;
    end
    return prod[7:0];
  endfunction

  function automatic logic [7:0] m_pow(input logic [7:0] a, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = m_mul(r, a);
    return r;
  endfunction

  // Issue one start and wait for done; lat is the cycle offset from T (0 on timeout).
  task automatic run_op(input logic [7:0] a, input logic s, output logic [7:0] y,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    din   = a;
    sel   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    y        = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        y   = dout;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    din   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", dout); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] y;
    int lat, bc;
    logic [7:0] vin [6] = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h01, 8'h01};
    logic       vsel[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] vexp[6] = '{8'h1B, 8'hD3, 8'h00, 8'h00, 8'h01, 8'h01};
    for (int i = 0; i < 6; i++) begin
      run_op(vin[i], vsel[i], y, lat, bc);
      checks++;
      if (y !== vexp[i]) begin
        errors++;
        $display("FAIL basic_dout din=%h sel=%b got=%h want=%h", vin[i], vsel[i], y, vexp[i]);
      end
      checks++;
      if (lat != 15) begin errors++; $display("FAIL basic_latency got=%0d want=15", lat); end
      checks++;
      if (bc != 14) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=14", bc); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt, first;
    logic [7:0] y;
    @(negedge clk);
    din = 8'h02; sel = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0; first = 0; y = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5);
      din   = (c == 5) ? 8'h55 : 8'h02;
      sel   = (c == 5);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first == 0) begin first = c + 1; y = dout; end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
    checks++;
    if (first != 15) begin errors++; $display("FAIL ignore_latency got=%0d want=15", first); end
    checks++;
    if (y !== 8'h1B) begin errors++; $display("FAIL ignore_dout got=%h want=1b", y); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] y;
    int lat, bc, held_bad, lat2;
    run_op(8'h02, 1'b0, y, lat, bc);
    checks++;
    if (y !== 8'h1B) begin errors++; $display("FAIL b2b_first got=%h want=1b", y); end
    // Still inside the done cycle: request the next operation right here.
    din = 8'h02; sel = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    held_bad = 0; lat2 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin lat2 = c; y = dout; break; end
      if (dout !== 8'h1B) held_bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (lat2 != 15) begin errors++; $display("FAIL b2b_latency got=%0d want=15", lat2); end
    checks++;
    if (y !== 8'hD3) begin errors++; $display("FAIL b2b_second got=%h want=d3", y); end
    checks++;
    if (held_bad != 0) begin errors++; $display("FAIL b2b_hold bad_cycles=%0d want=0", held_bad); end
  endtask

  task automatic test_rst_abort();
    int done_cnt;
    logic [7:0] y;
    int lat, bc;
    @(negedge clk);
    din = 8'h03; sel = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 7; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL abort_dout got=%h want=00", dout); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; din = 8'h02;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got=%b want=0", busy); end
    run_op(8'h02, 1'b0, y, lat, bc);
    checks++;
    if (y !== 8'h1B) begin errors++; $display("FAIL after_abort got=%h want=1b", y); end
  endtask

  task automatic test_exhaustive();
    logic [7:0] y, want, xk;
    int lat, bc;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 256; a++) begin
        run_op(8'(a), s[0], y, lat, bc);
        want = m_pow(8'(a), (s == 0) ? 247 : 251);
        checks++;
        if (y !== want) begin
          errors++;
          $display("FAIL exh_dout din=%h sel=%0d got=%h want=%h", a[7:0], s, y, want);
        end
        checks++;
        if (lat != 15) begin
          errors++;
          $display("FAIL exh_latency din=%h sel=%0d got=%0d want=15", a[7:0], s, lat);
        end
        if (a != 0) begin
          xk = m_pow(8'(a), (s == 0) ? 8 : 4);
          checks++;
          if (m_mul(y, xk) !== 8'h01) begin
            errors++;
            $display("FAIL exh_inverse din=%h sel=%0d got=%h want=01", a[7:0], s, m_mul(y, xk));
          end
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_rst_abort();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
